// File: rtl/addend_vector_loader_if.sv
// Bundle of the element-stream input handshake and the assembled-vector
// output handshake of the addend vector loader.
// The slave modport is the loader's view. The master modport is the view of
// whoever drives the stream and consumes the vector.
interface addend_vector_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  localparam int CNT_W     = $clog2(LENGTH + 1)
);

  // element stream into the loader
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_last;

  // assembled vector out of the loader
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_addends [LENGTH];
  logic [CNT_W-1:0]             out_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_addends,
    output out_count
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_addends,
    input  out_count
  );

endinterface

// File: rtl/addend_vector_loader.sv
// Addend vector loader.
// Collects signed elements, one per accepted beat, into a LENGTH-wide buffer.
// It then holds that buffer steady behind out_valid until the consumer takes it.
// The block is single-buffered, so input is stalled while a vector is held.
// A short vector is closed with in_last, and the positions it did not fill
// read as zero. Every output comes straight from a flop.
module addend_vector_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  localparam int CNT_W     = $clog2(LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addend_vector_loader_if.slave bus
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             last_elem;
  logic             release_vec;

  // Handshake qualifiers shared by the control FSM and the element registers.
  // in_ready_q is only ever high in FILL, so it alone gates acceptance.
  always_comb begin
    accept      = bus.in_valid && in_ready_q;
    last_elem   = (idx_q == CNT_W'(LENGTH - 1)) || bus.in_last;
    release_vec = (state_q == ST_HOLD) && out_valid_q && bus.out_ready;
  end

  // Next-state logic: walk idx through FILL, close the vector on the last slot
  // or on in_last, then hold it until the consumer handshakes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      ST_FILL: begin
        // Also raises in_ready on the first edge after reset release.
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (accept) begin
          idx_d = idx_q + 1'b1;
          if (last_elem) begin
            state_d     = ST_HOLD;
            count_d     = idx_q + 1'b1;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (release_vec) begin
          state_d     = ST_FILL;
          idx_d       = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_FILL;
        idx_d       = '0;
        count_d     = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  // Control registers. Reset discards any partial or held vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // One register per vector slot. A slot loads when the accepted element
  // targets it, and clears when the held vector is handed off. Clearing on
  // hand-off gives the zero padding for the next short vector for free.
  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_elem
      logic signed [DATA_WIDTH-1:0] elem_q, elem_d;

      // Slot update: clear on hand-off, load on a matching accept, else hold.
      always_comb begin
        elem_d = elem_q;
        if (release_vec) begin
          elem_d = '0;
        end else if (accept && (idx_q == CNT_W'(gi))) begin
          elem_d = bus.in_data;
        end
      end

      // Slot register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          elem_q <= '0;
        end else begin
          elem_q <= elem_d;
        end
      end

      assign bus.out_addends[gi] = elem_q;
    end
  endgenerate

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = count_q;

endmodule
